// File: rtl/mem_arb_pkg.sv
// Shared state and owner encodings for the memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      NONE,
      FETCH,
      DATA
   } owner_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter: cleared between transactions, counts while a request
// is outstanding and flags when the TIMEOUT limit has been reached.
module mem_wait_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] count;

   assign expired = (count == LIMIT);

   // Count wait cycles and hold once the limit is hit.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and data accesses.
// One transaction at a time: IDLE picks an owner, BUSY holds the request until
// ready or timeout, DONE pulses the owner's ack with registered read data.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int TIMEOUT    = 255,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              stall_if,
   output logic              stall_d
);

   localparam int LW = $clog2(STARVE_MAX + 1);
   localparam logic [LW-1:0] STARVE_LIM = LW'(STARVE_MAX);

   state_t          state;
   owner_t          owner;
   logic [LW-1:0]   loss_cnt;
   logic            pend_err;
   logic            expired;
   logic            data_req;
   logic            grant_fetch;
   logic [DATA_W-1:0] rd_cap;

   assign data_req = d_rd | d_wr;
   // Data is normally older than the fetch, so it wins unless fetch has starved.
   assign grant_fetch = if_req & (~data_req | (loss_cnt == STARVE_LIM));
   // Writes and timed-out accesses return zero read data.
   assign rd_cap = (mem_ready && !mem_we) ? mem_rdata : '0;

   assign stall_if = if_req & ~if_ack;
   assign stall_d  = data_req & ~d_ack;

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == IDLE),
      .en      (state == BUSY),
      .expired (expired)
   );

   // Arbitration FSM with registered memory-side and requester-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= NONE;
         loss_cnt  <= '0;
         pend_err  <= 1'b0;
         if_ack    <= 1'b0;
         if_rdata  <= '0;
         d_ack     <= 1'b0;
         d_rdata   <= '0;
         err       <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         err    <= 1'b0;
         case (state)
            IDLE: begin
               if (if_req || data_req) begin
                  state   <= BUSY;
                  mem_req <= 1'b1;
                  if (grant_fetch) begin
                     owner     <= FETCH;
                     mem_we    <= 1'b0;
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                     pend_err  <= 1'b0;
                     loss_cnt  <= '0;
                  end else begin
                     owner     <= DATA;
                     // A simultaneous read+write is performed as a write and flagged.
                     mem_we    <= d_wr;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     pend_err  <= d_rd & d_wr;
                     if (if_req && loss_cnt != STARVE_LIM)
                        loss_cnt <= loss_cnt + LW'(1);
                  end
               end
            end
            BUSY: begin
               if (mem_ready || expired) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  err     <= pend_err | ~mem_ready;
                  if (owner == FETCH) begin
                     if_ack   <= 1'b1;
                     if_rdata <= rd_cap;
                  end else begin
                     d_ack   <= 1'b1;
                     d_rdata <= rd_cap;
                  end
               end
            end
            DONE: begin
               // The request still visible here is the one just served; skip it.
               state    <= IDLE;
               owner    <= NONE;
               pend_err <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory responder, ack scoreboard,
// a vector table of single accesses and hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 8;
   localparam int SM = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_ack;
   logic [DW-1:0] if_rdata;
   logic          d_rd = 1'b0;
   logic          d_wr = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_ack;
   logic [DW-1:0] d_rdata;
   logic          err;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic          stall_if;
   logic          stall_d;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .STARVE_MAX(SM)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_d(stall_d)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] mem_val(input logic [15:0] a);
      return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
   endfunction

   // Memory responder: ready after wait_cfg wait states (-1 = never ready).
   int wait_cfg = 0;
   int wcnt = 0;
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req && !rst) begin
            if (wait_cfg >= 0 && wcnt == wait_cfg) begin
               mem_ready = 1'b1;
               mem_rdata = mem_we ? 16'h0000 : mem_val(mem_addr);
               wcnt = 0;
            end else begin
               mem_ready = 1'b0;
               mem_rdata = 16'hDEAD;
               wcnt++;
            end
         end else begin
            mem_ready = 1'b0;
            wcnt = 0;
         end
      end
   end

   // Scoreboard of expected acks.
   typedef struct {
      logic        is_data;
      logic [15:0] rdata;
      logic        err;
      int          at;
   } exp_t;
   exp_t sb[$];

   task automatic push_exp(input logic is_data, input logic [15:0] rdata,
                           input logic e, input int at);
      exp_t x;
      x.is_data = is_data;
      x.rdata   = rdata;
      x.err     = e;
      x.at      = at;
      sb.push_back(x);
   endtask

   // Memory-side expectations: 0 off, 1 fixed values, 2 track requester inputs.
   int          mon_mode = 0;
   logic        exp_we = 1'b0;
   logic [15:0] exp_addr = '0;
   logic [15:0] exp_wdata = '0;

   always @(negedge clk) begin
      exp_t e;
      if (if_ack || d_ack) begin
         if (sb.size() == 0) begin
            chk("unexpected_ack", {30'd0, if_ack, d_ack}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("ack_owner", {30'd0, if_ack, d_ack}, e.is_data ? 32'd1 : 32'd2);
            chk("ack_cycle", cyc, e.at);
            chk("ack_rdata", e.is_data ? d_rdata : if_rdata, {16'd0, e.rdata});
            chk("ack_err", {31'd0, err}, {31'd0, e.err});
         end
      end else begin
         chk("err_without_ack", {31'd0, err}, 32'd0);
      end
      if (mon_mode == 1 && mem_req) begin
         chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
         chk("mem_addr", mem_addr, exp_addr);
         if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (mon_mode == 2 && mem_req) begin
         if (mem_we) begin
            chk("wr_addr", mem_addr, d_addr);
            chk("wr_wdata", mem_wdata, d_wdata);
         end else begin
            chk("fetch_addr", mem_addr, if_addr);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input logic is_fetch, input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (is_fetch ? if_ack : d_ack) begin
            seen = 1'b1;
            break;
         end
      end
      chk(nm, {31'd0, seen}, 32'd1);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_mem_req"}, {31'd0, mem_req}, 32'd0);
      chk({nm, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      chk({nm, "_mem_addr"}, mem_addr, 32'd0);
      chk({nm, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({nm, "_acks"}, {30'd0, if_ack, d_ack}, 32'd0);
      chk({nm, "_if_rdata"}, if_rdata, 32'd0);
      chk({nm, "_d_rdata"}, d_rdata, 32'd0);
      chk({nm, "_err"}, {31'd0, err}, 32'd0);
      chk({nm, "_stalls"}, {30'd0, stall_if, stall_d}, 32'd0);
   endtask

   typedef struct {
      logic        fetch;
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          waits;
      logic [15:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vt[8];

   task automatic run_vec(input vec_t v);
      wait_cfg = v.waits;
      if (v.fetch) begin
         if_req  = 1'b1;
         if_addr = v.addr;
      end else begin
         d_rd    = v.rd;
         d_wr    = v.wr;
         d_addr  = v.addr;
         d_wdata = v.wdata;
      end
      exp_we    = v.wr;
      exp_addr  = v.addr;
      exp_wdata = v.wdata;
      mon_mode  = 1;
      push_exp(!v.fetch, v.exp_rdata, v.exp_err, cyc + v.exp_lat);
      @(negedge clk);
      chk("req_stall", {31'd0, v.fetch ? stall_if : stall_d}, 32'd1);
      wait_ack(v.fetch, "vec_ack_seen");
      tick();
      if_req   = 1'b0;
      d_rd     = 1'b0;
      d_wr     = 1'b0;
      mon_mode = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c0;
      //            fetch rd  wr  addr      wdata     wt  rdata     err lat
      vt[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 0,  16'h486E, 1'b0, 2};
      vt[1] = '{1'b0, 1'b1, 1'b0, 16'h00F0, 16'h0000, 3,  16'h5AAA, 1'b0, 5};
      vt[2] = '{1'b0, 1'b0, 1'b1, 16'h0200, 16'hCAFE, 1,  16'h0000, 1'b0, 3};
      vt[3] = '{1'b0, 1'b1, 1'b1, 16'h0300, 16'h1357, 0,  16'h0000, 1'b1, 2};
      vt[4] = '{1'b0, 1'b1, 1'b0, 16'h0400, 16'h0000, -1, 16'h0000, 1'b1, TO + 2};
      vt[5] = '{1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 2,  16'h5A7A, 1'b0, 4};
      vt[6] = '{1'b1, 1'b0, 1'b0, 16'h0060, 16'h0000, -1, 16'h0000, 1'b1, TO + 2};
      vt[7] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0,  16'hBEEF, 1'b0, 2};

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      tick();
      rst = 1'b0;
      tick();

      // Basic fetch, cycle by cycle.
      wait_cfg  = 0;
      mon_mode  = 1;
      exp_we    = 1'b0;
      exp_addr  = 16'h0010;
      if_req    = 1'b1;
      if_addr   = 16'h0010;
      push_exp(1'b0, 16'hBEEF, 1'b0, cyc + 2);
      @(negedge clk);
      chk("f_c0_stall_if", {31'd0, stall_if}, 32'd1);
      chk("f_c0_mem_req", {31'd0, mem_req}, 32'd0);
      chk("f_c0_stall_d", {31'd0, stall_d}, 32'd0);
      @(negedge clk);
      chk("f_c1_mem_req", {31'd0, mem_req}, 32'd1);
      chk("f_c1_stall_if", {31'd0, stall_if}, 32'd1);
      @(negedge clk);
      chk("f_c2_if_ack", {31'd0, if_ack}, 32'd1);
      chk("f_c2_if_rdata", if_rdata, 32'h0000BEEF);
      chk("f_c2_mem_req", {31'd0, mem_req}, 32'd0);
      chk("f_c2_stall_if", {31'd0, stall_if}, 32'd0);
      tick();
      if_req   = 1'b0;
      mon_mode = 0;
      @(negedge clk);
      chk("f_c3_if_ack", {31'd0, if_ack}, 32'd0);
      chk("f_c3_mem_req", {31'd0, mem_req}, 32'd0);
      tick();

      // Table of single accesses, including timeouts and read+write conflict.
      for (int i = 0; i < 8; i++) run_vec(vt[i]);

      // Data and fetch together: data first, fetch regranted after DONE.
      wait_cfg = 0;
      d_rd     = 1'b1;
      d_addr   = 16'h0100;
      if_req   = 1'b1;
      if_addr  = 16'h0030;
      c0 = cyc;
      push_exp(1'b1, 16'h5B5A, 1'b0, c0 + 2);
      push_exp(1'b0, 16'h5A6A, 1'b0, c0 + 5);
      wait_ack(1'b0, "arb_d_ack_seen");
      tick();
      d_rd = 1'b0;
      wait_ack(1'b1, "arb_if_ack_seen");
      tick();
      if_req = 1'b0;

      // Continuous writes against a waiting fetch: fetch forced after 4 losses.
      mon_mode = 2;
      d_wr     = 1'b1;
      d_addr   = 16'h0500;
      d_wdata  = 16'h1111;
      if_req   = 1'b1;
      if_addr  = 16'h0040;
      c0 = cyc;
      for (int k = 0; k < SM; k++) push_exp(1'b1, 16'h0000, 1'b0, c0 + 2 + 3 * k);
      push_exp(1'b0, 16'h5A1A, 1'b0, c0 + 2 + 3 * SM);
      for (int k = 0; k < SM; k++) begin
         wait_ack(1'b0, "starve_d_ack_seen");
         tick();
         d_addr  = 16'h0501 + 16'(k);
         d_wdata = 16'h1111 * 16'(k + 2);
      end
      wait_ack(1'b1, "starve_if_ack_seen");
      tick();
      d_wr     = 1'b0;
      if_req   = 1'b0;
      mon_mode = 0;
      tick();

      // Reset while BUSY with wait states pending.
      wait_cfg = 3;
      if_req   = 1'b1;
      if_addr  = 16'h0050;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("rstmid_busy", {31'd0, mem_req}, 32'd1);
      tick();
      rst = 1'b1;
      tick();
      if_req = 1'b0;
      @(negedge clk);
      chk_all_zero("rstmid");
      tick();
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("rstmid_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
      end
      tick();
      run_vec('{1'b1, 1'b0, 1'b0, 16'h0070, 16'h0000, 1, 16'h5A2A, 1'b0, 3});

      repeat (4) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter and sequencer sharing the CPU's single memory port between instruction fetch and the data accesses (LD/ST/PUSH/POP) decoded by the control unit's `memrd`/`memwr`. It grants one requester at a time, holds the memory request stable until the memory reports ready, returns a one-cycle acknowledge with registered read data, and generates the pipeline stall signals. A wait-state timeout guarantees forward progress when memory never responds.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `TIMEOUT`, 255, max cycles waiting for `mem_ready` before abort (≥1)
- `STARVE_MAX`, 4, consecutive fetch losses before fetch is forced to win

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_ack`
- `if_addr`  in  ADDR_W  fetch address
- `if_ack`  out  1  one-cycle fetch completion
- `if_rdata`  out  DATA_W  fetched word, valid while `if_ack`
- `d_rd`  in  1  data read (from `memrd`)
- `d_wr`  in  1  data write (from `memwr`)
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_ack`  out  1  one-cycle data completion
- `d_rdata`  out  DATA_W  load data, valid while `d_ack`
- `err`  out  1  one-cycle pulse with an ack on timeout, or on `d_rd & d_wr`
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1 = write
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ready`
- `mem_ready`  in  1  memory completes the current request
- `stall_if`  out  1  `if_req & ~if_ack`
- `stall_d`  out  1  `(d_rd | d_wr) & ~d_ack`

## Operation
- FSM states: IDLE, BUSY, DONE. Owner register: NONE, FETCH, DATA.
- IDLE: if any request is present, pick an owner, latch address/we/wdata into the `mem_*` registers, clear the wait counter, and go to BUSY.
  - Data wins over fetch (older instruction), unless the fetch-loss counter equals `STARVE_MAX`; then fetch wins.
  - Fetch-loss counter: increments when both request and data wins; clears when fetch is granted; saturates at `STARVE_MAX`.
- BUSY: `mem_req`=1 with registered, stable outputs. The wait counter increments each cycle.
  - `mem_ready`=1: capture `mem_rdata` (reads only), go to DONE.
  - Counter reaches `TIMEOUT` without ready: set the pending-error flag, read data = 0, go to DONE.
- DONE: the owner's ack = 1 for exactly one cycle with its rdata, `err` = pending flag. Then go to IDLE.
  - The request sampled in DONE is never re-granted. IDLE re-evaluates next cycle.
- `d_rd & d_wr` both high: perform a write, and assert `err` with `d_ack`.
- A requester dropping its request while BUSY is illegal. The memory access still completes and the ack still pulses.
- Outputs never change owner mid-transaction. A non-owner's ack stays 0.

## Timing
- Reset: state IDLE, owner NONE, every output 0 (`mem_*`, acks, rdata, `err`). Counters 0.
- Reset asserted mid-transaction aborts it. `mem_req` is 0 from the cycle after the reset edge, and no ack is issued.
- Latency, request to ack: 2 + wait states. Request seen in IDLE at cycle 0, `mem_req` in cycle 1, ready in cycle 1, ack in cycle 2.
- Throughput: one access per 3 cycles with zero-wait memory.
- Timeout: with no ready, ack and `err` arrive in cycle `TIMEOUT`+2 after the request.
- Stall outputs are combinational from the inputs and the registered acks.
- Wait counter width `$clog2(TIMEOUT+1)`. Loss counter width `$clog2(STARVE_MAX+1)`.

## Structure
- `mem_arb_pkg`: state enum (IDLE/BUSY/DONE) and owner enum (NONE/FETCH/DATA).
- One sub-module, `mem_wait_timer`: a clear/enable counter with a `TIMEOUT` compare that outputs `expired`.

## Test plan
- Fetch `if_addr`=0x0010, memory ready in cycle 1, data 0xBEEF → `mem_req` in cycle 1 only, `if_ack` and `if_rdata`=0xBEEF in cycle 2, `stall_if` high in cycles 0–1.
- `d_rd` and `if_req` both raised in cycle 0 → data served first (ack in cycle 2), fetch granted in cycle 3, fetch ack in cycle 5.
- Continuous `d_wr` plus `if_req` → fetch wins after the 4th loss. `mem_we`=1 with correct `d_wdata`/`d_addr` on every write.
- `mem_ready` held 0 with `TIMEOUT`=8 → `d_ack`, `err`, `d_rdata`=0 at cycle 10; next request proceeds normally.
- `rst` asserted while BUSY with 3 wait states → `mem_req`=0 next cycle, no ack ever, all outputs 0. Then a new fetch completes normally.
- `d_rd`=`d_wr`=1 → write issued, `d_ack` and `err` pulse together.
